mcpu_ctrl_fsm: RTL and testbench

MCPU_CTRL_FSM -- requirements
Module: mcpu_ctrl_fsm

---
 rtl/mcpu_ctrl_fsm.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory
// access and write-back, and drives every datapath select and write enable.
// Optional build macro MCPU_PERF_CNT_EN adds cycle_cnt / instret_cnt.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IF       | fetch at PC, IR <= mem, PC <= PC+4 once the bus is ready
// ID       | decode; ALUOut <= oldPC + imm for branch/jal/auipc
// EX_R     | register-register ALU op
// EX_I     | register-immediate ALU op
// EX_MA    | load/store address = rs1 + imm, latch access length
// MEM_RD   | load bus access, stalls on MIO_ready
// MEM_WR   | store bus access, stalls on MIO_ready
// WB_LD    | write load data to rd
// WB_ALU   | write ALUOut to rd
// EX_BR    | compare rs1/rs2, PC <= ALUOut when taken
// EX_JAL   | rd <= PC, PC <= ALUOut
// EX_JALR  | rd <= PC, PC <= (rs1 + imm) & ~1
// EX_LUI   | rd <= immU
// EX_AUIPC | rd <= ALUOut (oldPC + immU)
// TRAP     | unsupported encoding, parked until reset
module mcpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       MIO_ready,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemRW,
    output logic       CPU_MIO,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [3:0] ALU_Control,
    output logic [2:0] ImmSel,
    output logic [2:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [2:0] Length,
    output logic [3:0] state,
    output logic       illegal
`ifdef MCPU_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [3:0] S_IF       = 4'd0;
    localparam logic [3:0] S_ID       = 4'd1;
    localparam logic [3:0] S_EX_R     = 4'd2;
    localparam logic [3:0] S_EX_I     = 4'd3;
    localparam logic [3:0] S_EX_MA    = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_LD    = 4'd7;
    localparam logic [3:0] S_WB_ALU   = 4'd8;
    localparam logic [3:0] S_EX_BR    = 4'd9;
    localparam logic [3:0] S_EX_JAL   = 4'd10;
    localparam logic [3:0] S_EX_JALR  = 4'd11;
    localparam logic [3:0] S_EX_LUI   = 4'd12;
    localparam logic [3:0] S_EX_AUIPC = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    logic [3:0] state_q, state_d;
    logic [2:0] len_q, len_d;
    logic       is_store;
    logic       len_ok;
    logic [2:0] len_map;
    logic [3:0] alu_r, alu_i;
    logic       br_ok, br_taken;

    assign state    = state_q;
    assign is_store = (OPcode == 5'b01000);

    // Decode helpers: access length, ALU op and branch condition from funct fields
    always_comb begin
        len_ok  = 1'b0;
        len_map = 3'b000;
        if (is_store) begin
            case (Fun3)
                3'b000:  begin len_ok = 1'b1; len_map = 3'b000; end
                3'b001:  begin len_ok = 1'b1; len_map = 3'b010; end
                3'b010:  begin len_ok = 1'b1; len_map = 3'b100; end
                default: begin len_ok = 1'b0; len_map = 3'b000; end
            endcase
        end else begin
            case (Fun3)
                3'b000:  begin len_ok = 1'b1; len_map = 3'b001; end
                3'b001:  begin len_ok = 1'b1; len_map = 3'b011; end
                3'b010:  begin len_ok = 1'b1; len_map = 3'b100; end
                3'b100:  begin len_ok = 1'b1; len_map = 3'b000; end
                3'b101:  begin len_ok = 1'b1; len_map = 3'b010; end
                default: begin len_ok = 1'b0; len_map = 3'b000; end
            endcase
        end

        case (Fun3)
            3'b000:  alu_r = Fun7 ? ALU_SUB : ALU_ADD;
            3'b001:  alu_r = ALU_SLL;
            3'b010:  alu_r = ALU_SLT;
            3'b011:  alu_r = ALU_SLTU;
            3'b100:  alu_r = ALU_XOR;
            3'b101:  alu_r = Fun7 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_r = ALU_OR;
            default: alu_r = ALU_AND;
        endcase
        // addi has no subtract form; bit 30 there is part of the immediate
        alu_i = (Fun3 == 3'b000) ? ALU_ADD : alu_r;

        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (Fun3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_ok    = 1'b0;
        endcase
    end

    // Next-state and Moore/Mealy output decode, enables gated while in reset
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemRW       = 1'b0;
        CPU_MIO     = 1'b0;
        ALUSrc_A    = 2'b00;
        ALUSrc_B    = 2'b00;
        ALU_Control = ALU_ADD;
        ImmSel      = 3'b000;
        MemtoReg    = 3'b000;
        PCSource    = 2'b00;
        Length      = 3'b000;
        illegal     = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                if (MIO_ready) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrc_B = 2'b10;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                ALUSrc_A = 2'b10;
                ALUSrc_B = 2'b01;
                case (OPcode)
                    5'b11000: ImmSel = 3'b010;
                    5'b11011: ImmSel = 3'b100;
                    5'b00101: ImmSel = 3'b011;
                    default:  ImmSel = 3'b000;
                endcase
                case (OPcode)
                    5'b01100: state_d = S_EX_R;
                    5'b00100: state_d = S_EX_I;
                    5'b00000,
                    5'b01000: state_d = S_EX_MA;
                    5'b11000: state_d = S_EX_BR;
                    5'b11011: state_d = S_EX_JAL;
                    5'b11001: state_d = S_EX_JALR;
                    5'b01101: state_d = S_EX_LUI;
                    5'b00101: state_d = S_EX_AUIPC;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_EX_R: begin
                ALUSrc_A    = 2'b01;
                ALU_Control = alu_r;
                state_d     = S_WB_ALU;
            end
            S_EX_I: begin
                ALUSrc_A    = 2'b01;
                ALUSrc_B    = 2'b01;
                ALU_Control = alu_i;
                state_d     = S_WB_ALU;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
            end
            S_EX_MA: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b01;
                ImmSel   = is_store ? 3'b001 : 3'b000;
                if (len_ok) begin
                    len_d   = len_map;
                    state_d = is_store ? S_MEM_WR : S_MEM_RD;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                Length  = len_q;
                if (MIO_ready) state_d = S_WB_LD;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 3'b001;
                Length   = len_q;
                state_d  = S_IF;
            end
            S_MEM_WR: begin
                IorD    = 1'b1;
                MemRW   = 1'b1;
                CPU_MIO = 1'b1;
                Length  = len_q;
                if (MIO_ready) state_d = S_IF;
            end
            S_EX_BR: begin
                ALUSrc_A    = 2'b01;
                ALU_Control = ALU_SUB;
                if (!br_ok) begin
                    state_d = S_TRAP;
                end else begin
                    if (br_taken) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b01;
                    end
                    state_d = S_IF;
                end
            end
            S_EX_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = 3'b010;
                PCWrite  = 1'b1;
                PCSource = 2'b01;
                state_d  = S_IF;
            end
            S_EX_JALR: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b01;
                RegWrite = 1'b1;
                MemtoReg = 3'b010;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_IF;
            end
            S_EX_LUI: begin
                RegWrite = 1'b1;
                MemtoReg = 3'b011;
                ImmSel   = 3'b011;
                state_d  = S_IF;
            end
            S_EX_AUIPC: begin
                RegWrite = 1'b1;
                MemtoReg = 3'b100;
                state_d  = S_IF;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset must kill any in-flight bus access or register write at once
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRW    = 1'b0;
            MemRead  = 1'b0;
            CPU_MIO  = 1'b0;
        end
    end

    // State and latched access length
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IF;
            len_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

`ifdef MCPU_PERF_CNT_EN
    // Free-running cycle count and retirement count (each return to IF retires one)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if ((state_q != S_IF) && (state_d == S_IF))
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: walks each instruction class through the
// FSM and compares state plus a packed control word against hand values.
module tb_mcpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       MIO_ready;
    logic       zero, lt, ltu;
    logic       PCWrite, IRWrite, RegWrite, IorD, MemRead, MemRW, CPU_MIO;
    logic [1:0] ALUSrc_A, ALUSrc_B, PCSource;
    logic [3:0] ALU_Control, state;
    logic [2:0] ImmSel, MemtoReg, Length;
    logic       illegal;
`ifdef MCPU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mcpu_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
        .MIO_ready(MIO_ready), .zero(zero), .lt(lt), .ltu(ltu),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .IorD(IorD),
        .MemRead(MemRead), .MemRW(MemRW), .CPU_MIO(CPU_MIO),
        .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control),
        .ImmSel(ImmSel), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .Length(Length), .state(state), .illegal(illegal)
`ifdef MCPU_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // {PCWrite,IRWrite,RegWrite,IorD,MemRead,MemRW,CPU_MIO,A,B,ALU,Imm,M2R,PCSrc,Len,illegal}
    logic [26:0] obs_cw;
    assign obs_cw = {PCWrite, IRWrite, RegWrite, IorD, MemRead, MemRW, CPU_MIO,
                     ALUSrc_A, ALUSrc_B, ALU_Control, ImmSel, MemtoReg,
                     PCSource, Length, illegal};

    function automatic logic [26:0] cw(
        input logic pcw, input logic irw, input logic rw, input logic iord,
        input logic mr, input logic mw, input logic mio,
        input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
        input logic [2:0] imm, input logic [2:0] m2r, input logic [1:0] pcs,
        input logic [2:0] len, input logic ill);
        return {pcw, irw, rw, iord, mr, mw, mio, a, b, alu, imm, m2r, pcs, len, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sc(input string tag, input logic [3:0] exp_state, input logic [26:0] exp_cw);
        #1;
        chk({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
        chk({tag, ".cw"}, {5'd0, obs_cw}, {5'd0, exp_cw});
    endtask

    task automatic set_inst(input logic [4:0] op, input logic [2:0] f3, input logic f7);
        OPcode = op;
        Fun3   = f3;
        Fun7   = f7;
    endtask

    localparam logic [26:0] CW_IF_GO   = 27'({1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b10,4'b0000,3'b000,3'b000,2'b00,3'b000,1'b0});
    localparam logic [26:0] CW_ID_I    = 27'({7'b0,2'b10,2'b01,4'b0000,3'b000,3'b000,2'b00,3'b000,1'b0});
    localparam logic [26:0] CW_WB_ALU  = 27'({3'b001,4'b0000,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,1'b0});
    localparam logic [26:0] CW_TRAP    = 27'({7'b0,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,1'b1});

    initial begin
        rst_n = 1'b0; MIO_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        set_inst(5'b01100, 3'b000, 1'b1);

        // Reset: IF, enables forced low even with MIO_ready high
        tick();
        chk_sc("rst", 4'd0, cw(0,0,0,0,0,0,0,2'b00,2'b10,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        rst_n = 1'b1;
        chk_sc("if_go", 4'd0, CW_IF_GO);
        MIO_ready = 1'b0;
        chk_sc("if_stall", 4'd0, cw(0,0,0,0,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        tick();
        chk_sc("if_stall2", 4'd0, cw(0,0,0,0,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        MIO_ready = 1'b1;

        // sub (add opcode with Fun7=1): 0,1,2,8,0
        tick(); chk_sc("sub.id", 4'd1, CW_ID_I);
        tick(); chk_sc("sub.ex", 4'd2, cw(0,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b00,3'b000,0));
        tick(); chk_sc("sub.wb", 4'd8, CW_WB_ALU);
        tick(); chk_sc("sub.if", 4'd0, CW_IF_GO);

        // R-type or, Fun3 110
        set_inst(5'b01100, 3'b110, 1'b0);
        tick(); tick();
        chk_sc("or.ex", 4'd2, cw(0,0,0,0,0,0,0,2'b01,2'b00,4'b1000,3'b000,3'b000,2'b00,3'b000,0));
        tick(); tick();

        // srai then addi with bit30 set (still add)
        set_inst(5'b00100, 3'b101, 1'b1);
        tick(); tick();
        chk_sc("srai.ex", 4'd3, cw(0,0,0,0,0,0,0,2'b01,2'b01,4'b0111,3'b000,3'b000,2'b00,3'b000,0));
        tick(); chk_sc("srai.wb", 4'd8, CW_WB_ALU);
        tick();
        set_inst(5'b00100, 3'b000, 1'b1);
        tick(); tick();
        chk_sc("addi.ex", 4'd3, cw(0,0,0,0,0,0,0,2'b01,2'b01,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        tick(); tick();

        // lw with 3 stall cycles in MEM_RD: 8 cycles total
        set_inst(5'b00000, 3'b010, 1'b0);
        chk_sc("lw.if", 4'd0, CW_IF_GO);
        tick(); chk_sc("lw.id", 4'd1, CW_ID_I);
        tick(); chk_sc("lw.ma", 4'd4, cw(0,0,0,0,0,0,0,2'b01,2'b01,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        tick();
        MIO_ready = 1'b0;
        chk_sc("lw.rd0", 4'd5, cw(0,0,0,1,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick(); chk_sc("lw.rd1", 4'd5, cw(0,0,0,1,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick(); chk_sc("lw.rd2", 4'd5, cw(0,0,0,1,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick();
        MIO_ready = 1'b1;
        chk_sc("lw.rd3", 4'd5, cw(0,0,0,1,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick(); chk_sc("lw.wb", 4'd7, cw(0,0,1,0,0,0,0,2'b00,2'b00,4'b0000,3'b000,3'b001,2'b00,3'b100,0));
        tick(); chk_sc("lw.if2", 4'd0, CW_IF_GO);

        // lbu (Fun3 100) length 000
        set_inst(5'b00000, 3'b100, 1'b0);
        tick(); tick(); tick();
        chk_sc("lbu.rd", 4'd5, cw(0,0,0,1,1,0,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        tick(); tick();

        // sh: EX_MA ImmSel S, MEM_WR length 010
        set_inst(5'b01000, 3'b001, 1'b0);
        tick(); tick();
        chk_sc("sh.ma", 4'd4, cw(0,0,0,0,0,0,0,2'b01,2'b01,4'b0000,3'b001,3'b000,2'b00,3'b000,0));
        tick();
        chk_sc("sh.wr", 4'd6, cw(0,0,0,1,0,1,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b010,0));
        tick(); chk_sc("sh.if", 4'd0, CW_IF_GO);

        // beq taken / not taken
        set_inst(5'b11000, 3'b000, 1'b0);
        tick(); chk_sc("beq.id", 4'd1, cw(0,0,0,0,0,0,0,2'b10,2'b01,4'b0000,3'b010,3'b000,2'b00,3'b000,0));
        tick();
        zero = 1'b1;
        chk_sc("beq.t", 4'd9, cw(1,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b01,3'b000,0));
        zero = 1'b0;
        chk_sc("beq.nt", 4'd9, cw(0,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b00,3'b000,0));
        tick(); chk_sc("beq.if", 4'd0, CW_IF_GO);

        // bgeu: ltu 0 taken, ltu 1 not taken; blt lt 1 taken
        set_inst(5'b11000, 3'b111, 1'b0);
        tick(); tick();
        ltu = 1'b0;
        chk_sc("bgeu.t", 4'd9, cw(1,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b01,3'b000,0));
        ltu = 1'b1;
        chk_sc("bgeu.nt", 4'd9, cw(0,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b00,3'b000,0));
        tick();
        set_inst(5'b11000, 3'b100, 1'b0);
        lt = 1'b1; ltu = 1'b0;
        tick(); tick();
        chk_sc("blt.t", 4'd9, cw(1,0,0,0,0,0,0,2'b01,2'b00,4'b0001,3'b000,3'b000,2'b01,3'b000,0));
        tick();
        lt = 1'b0;

        // jal, jalr, lui, auipc
        set_inst(5'b11011, 3'b000, 1'b0);
        tick(); chk_sc("jal.id", 4'd1, cw(0,0,0,0,0,0,0,2'b10,2'b01,4'b0000,3'b100,3'b000,2'b00,3'b000,0));
        tick(); chk_sc("jal.ex", 4'd10, cw(1,0,1,0,0,0,0,2'b00,2'b00,4'b0000,3'b000,3'b010,2'b01,3'b000,0));
        tick(); chk_sc("jal.if", 4'd0, CW_IF_GO);
        set_inst(5'b11001, 3'b000, 1'b0);
        tick(); tick();
        chk_sc("jalr.ex", 4'd11, cw(1,0,1,0,0,0,0,2'b01,2'b01,4'b0000,3'b000,3'b010,2'b10,3'b000,0));
        tick();
        set_inst(5'b01101, 3'b000, 1'b0);
        tick(); tick();
        chk_sc("lui.ex", 4'd12, cw(0,0,1,0,0,0,0,2'b00,2'b00,4'b0000,3'b011,3'b011,2'b00,3'b000,0));
        tick();
        set_inst(5'b00101, 3'b000, 1'b0);
        tick(); chk_sc("auipc.id", 4'd1, cw(0,0,0,0,0,0,0,2'b10,2'b01,4'b0000,3'b011,3'b000,2'b00,3'b000,0));
        tick(); chk_sc("auipc.ex", 4'd13, cw(0,0,1,0,0,0,0,2'b00,2'b00,4'b0000,3'b000,3'b100,2'b00,3'b000,0));
        tick(); chk_sc("auipc.if", 4'd0, CW_IF_GO);

        // Illegal opcode: TRAP held 20 cycles with no enables, then reset
        set_inst(5'b11111, 3'b000, 1'b0);
        tick(); chk_sc("ill.id", 4'd1, CW_ID_I);
        for (int i = 0; i < 20; i++) begin
            tick();
            MIO_ready = i[0];
            chk_sc("ill.trap", 4'd15, CW_TRAP);
        end
        MIO_ready = 1'b1;
        rst_n = 1'b0;
        chk_sc("ill.rst", 4'd15, CW_TRAP);
        tick();
        rst_n = 1'b1;
        chk_sc("ill.after", 4'd0, CW_IF_GO);

        // Bad load width and bad branch funct3 both trap
        set_inst(5'b00000, 3'b011, 1'b0);
        tick(); tick(); tick();
        chk_sc("ldbad", 4'd15, CW_TRAP);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_inst(5'b11000, 3'b010, 1'b0);
        tick(); tick(); tick();
        chk_sc("brbad", 4'd15, CW_TRAP);
        rst_n = 1'b0; tick(); rst_n = 1'b1;

        // Reset during a stalled store aborts the access
        set_inst(5'b01000, 3'b010, 1'b0);
        tick(); tick(); tick();
        MIO_ready = 1'b0;
        chk_sc("sw.stall", 4'd6, cw(0,0,0,1,0,1,1,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick();
        rst_n = 1'b0;
        chk_sc("sw.rst", 4'd6, cw(0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b100,0));
        tick();
        chk_sc("sw.abort", 4'd0, cw(0,0,0,0,0,0,0,2'b00,2'b00,4'b0000,3'b000,3'b000,2'b00,3'b000,0));
        rst_n = 1'b1;
        MIO_ready = 1'b1;

`ifdef MCPU_PERF_CNT_EN
        // Four back-to-back adds from reset: 16 cycles, 4 retired
        rst_n = 1'b0;
        set_inst(5'b01100, 3'b000, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("perf.cyc0", cycle_cnt, 32'd0);
        for (int i = 0; i < 16; i++) tick();
        #1;
        chk("perf.cyc", cycle_cnt, 32'd16);
        chk("perf.ret", instret_cnt, 32'd4);
        chk("perf.state", {28'd0, state}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
